// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, counter width helper and line idle level.
package uart_pkg;

    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Bits needed to hold a count of 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-runs 0..CLKS_PER_BIT-1 and flags the half-period and full-period points.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic half_tick,
    output logic full_tick
);

    localparam int CNT_W = cnt_w(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == FULL_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign half_tick = (cnt == HALF_LAST);
    assign full_tick = (cnt == FULL_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with false-start rejection, framing check and a valid/ready output register.
// Define UART_RX_PARITY_EN to add a parity bit after the data (PARITY_ODD selects odd parity).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy,
    output state_t            fsm_state
);

    // Output handshake: a word transfers on any clock edge where rx_valid && rx_ready;
    // rx_data is held stable for as long as rx_valid is high.

    localparam int BIT_W = cnt_w(DATA_W);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    state_t            state, state_next;
    logic              rx_meta, rx_s, rx_prev;
    logic              fall;
    logic              timer_restart, half_tick, full_tick;
    logic [BIT_W-1:0]  bit_cnt;
    logic              bit_clr, bit_inc;
    logic              shift_en;
    logic [DATA_W-1:0] shift_reg;
    logic              frame_bad, word_done, accept;
`ifdef UART_RX_PARITY_EN
    logic              par_capture, par_acc, par_bad;
`endif

    // Synchroniser presets to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= UART_IDLE_LVL;
            rx_s    <= UART_IDLE_LVL;
            rx_prev <= UART_IDLE_LVL;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall = (rx_prev == UART_IDLE_LVL) && (rx_s != UART_IDLE_LVL);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (timer_restart),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        timer_restart = 1'b0;
        bit_clr       = 1'b0;
        bit_inc       = 1'b0;
        shift_en      = 1'b0;
        frame_bad     = 1'b0;
        word_done     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_capture   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                timer_restart = 1'b1;
                bit_clr       = 1'b1;
                if (fall) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (half_tick) begin
                    if (rx_s == UART_IDLE_LVL) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next    = S_DATA;
                        timer_restart = 1'b1;
                        bit_clr       = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (full_tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (full_tick) begin
                    par_capture = 1'b1;
                    state_next  = S_STOP;
                end
`else
                state_next = S_IDLE;
`endif
            end
            S_STOP: begin
                if (full_tick) begin
                    if (rx_s != UART_IDLE_LVL) begin
                        frame_bad  = 1'b1;
                        state_next = S_IDLE;
                    end else if (bit_cnt == STOP_LAST) begin
                        word_done  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // bit_cnt counts data bits, then is reused to count stop bits.
    always_ff @(posedge clk) begin
        if (rst || bit_clr) begin
            bit_cnt <= '0;
        end else if (bit_inc) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
        end
    end

    assign accept = word_done && (!rx_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= word_done && rx_valid && !rx_ready;
            if (accept) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error is reported alongside the delivered word, so a framing error suppresses it.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= word_done && par_bad;
            if (state == S_IDLE) begin
                par_acc <= 1'b0;
            end else if (shift_en) begin
                par_acc <= par_acc ^ rx_s;
            end
            if (par_capture) begin
                par_bad <= ((par_acc ^ rx_s) != PARITY_ODD);
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (DATA_W=8, CLKS_PER_BIT=16, STOP_BITS=1); parity case when UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int DATA_W    = 8;
    localparam int CPB       = 16;
    localparam int STOP_BITS = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;
    logic              busy;
    state_t            fsm_state;

    uart_rx_param #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (STOP_BITS)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD  (1'b0)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
    int valid_cycles = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    logic valid_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor samples on the falling edge, where outputs and rx_ready are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_valid && !valid_prev) rise_cyc = cyc;
            if (rx_valid) valid_cycles++;
            if (frame_err) fe_cnt++;
            if (parity_err) pe_cnt++;
            if (overrun) ov_cnt++;
        end
        valid_prev = rx_valid;
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input logic stop_lvl);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) drive_bit(data[i]);
        for (int i = 0; i < STOP_BITS; i++) drive_bit(stop_lvl);
        rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [DATA_W-1:0] data, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) drive_bit(data[i]);
        drive_bit(par_bit);
        for (int i = 0; i < STOP_BITS; i++) drive_bit(1'b1);
        rx = 1'b1;
    endtask
`endif

    task automatic check_words(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        tick(4);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_state", fsm_state, S_IDLE);
        check("reset_errs", {frame_err, parity_err, overrun}, 0);
        rst = 1'b0;
        tick(2 * CPB);

        // 1: single word, ready high; valid rises 155 edges after the start bit is driven
        start_cyc = cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(CPB);
        check("t1_latency", rise_cyc - start_cyc, 155);
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_valid_low", rx_valid, 0);
        check_words("t1");
        check("t1_no_errs", fe_cnt + pe_cnt + ov_cnt, 0);

        // 2: 4-cycle glitch is rejected at the mid-start sample
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2);
        check("t2_busy_in_start", busy, 1);
        tick(10);
        check("t2_busy_cleared", busy, 0);
        check("t2_state_idle", fsm_state, S_IDLE);
        tick(2 * CPB);
        check_words("t2");
        check("t2_valid_cycles", valid_cycles, 1);

        // 3: stop bit low -> frame error, word discarded; next frame still received
        send_frame(8'h3C, 1'b0);
        tick(2 * CPB);
        check("t3_frame_err", fe_cnt, 1);
        check("t3_valid_low", rx_valid, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        tick(CPB);
        check_words("t3");
        check("t3_frame_err_after", fe_cnt, 1);

        // 4: consumer stalled -> first word held, second dropped with overrun
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(CPB);
        check("t4_overrun", ov_cnt, 1);
        check("t4_valid_held", rx_valid, 1);
        check("t4_data_held", rx_data, 8'h11);
        exp_q.push_back(8'h11);
        rx_ready = 1'b1;
        tick(2);
        check("t4_valid_cleared", rx_valid, 0);
        check_words("t4");

        // 5: reset mid-frame aborts the 0xFF word silently
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        tick(2);
        rst = 1'b0;
        check("t5_busy_after_rst", busy, 0);
        check("t5_valid_after_rst", rx_valid, 0);
        tick(2 * CPB);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        tick(CPB);
        check_words("t5");
        check("t5_errs", {fe_cnt[7:0], ov_cnt[7:0]}, {8'd1, 8'd1});

`ifdef UART_RX_PARITY_EN
        // 6: even parity; 0x07 needs parity 1, so 0 is flagged but the word is delivered
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b0);
        tick(CPB);
        check("t6_parity_err", pe_cnt, 1);
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1);
        tick(CPB);
        check("t6_parity_ok", pe_cnt, 1);
        check_words("t6");
`else
        check("no_parity_err", pe_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
